// File: rtl/r2r_pkg.sv
// Shared definitions for the R2R SAR ADC controller: FSM state encoding,
// DAC width and the default per-bit settle budget.
package r2r_pkg;

   // Resolution of the existing R2R DAC
   localparam int unsigned DAC_WIDTH = 32'd8;

   // Default clocks per bit for DAC settling plus comparator synchronisation
   localparam int unsigned SETTLE_DEFAULT = 32'd4;

   // Conversion FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DECIDE = 2'd2,
      ST_DONE   = 2'd3
   } sar_state_e;

endpackage

// File: rtl/r2r_comp_sync.sv
// Two-flop synchroniser for the asynchronous analog comparator output.
module r2r_comp_sync (
   input  logic clk,
   input  logic n_rst,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // Double-register the comparator pin into the clk domain
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/r2r_sar_adc.sv
// Successive-approximation ADC controller driving the R2R DAC and reading
// back one external comparator. Binary-searches the input level MSB first,
// spending SETTLE cycles per trial code before sampling the comparator.
// Optional feature: define R2R_SAR_CONTINUOUS_EN for free-running conversions
// after the first accepted start.
module r2r_sar_adc
   import r2r_pkg::*;
#(
   parameter int unsigned WIDTH  = DAC_WIDTH,
   parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start,
   input  logic             comp_in,
   output logic [WIDTH-1:0] r2r_out,
   output logic [WIDTH-1:0] result,
   output logic             valid,
   output logic             busy
);

   localparam int unsigned IDX_W = (WIDTH > 32'd1) ? $clog2(WIDTH) : 32'd1;
   localparam int unsigned CNT_W = $clog2(SETTLE);

   localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 32'd1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};

   sar_state_e       state_r;
   sar_state_e       state_nxt_s;
   logic [IDX_W-1:0] idx_r;
   logic [IDX_W-1:0] idx_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [WIDTH-1:0] code_r;
   logic [WIDTH-1:0] code_nxt_s;
   logic [WIDTH-1:0] result_r;
   logic [WIDTH-1:0] result_nxt_s;
   logic             valid_r;
   logic             valid_nxt_s;
   logic             busy_r;
   logic             busy_nxt_s;
   logic             comp_s;

   r2r_comp_sync u_comp_sync (
      .clk   (clk),
      .n_rst (n_rst),
      .d     (comp_in),
      .q     (comp_s)
   );

   // FSM state register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = ST_SETTLE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_r == CNT_ZERO) begin
               state_nxt_s = ST_DECIDE;
            end else begin
               state_nxt_s = ST_SETTLE;
            end
         end
         ST_DECIDE: begin
            if (idx_r == IDX_ZERO) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_SETTLE;
            end
         end
         ST_DONE: begin
`ifdef R2R_SAR_CONTINUOUS_EN
            // Free-running: DONE is only ever reached after an accepted start
            state_nxt_s = ST_SETTLE;
`else
            state_nxt_s = ST_IDLE;
`endif
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Datapath and output next values; all outputs leave the block registered
   always_comb begin
      idx_nxt_s    = idx_r;
      cnt_nxt_s    = cnt_r;
      code_nxt_s   = code_r;
      result_nxt_s = result_r;
      valid_nxt_s  = 1'b0;
      busy_nxt_s   = busy_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               idx_nxt_s  = IDX_MSB;
               cnt_nxt_s  = CNT_LOAD;
               code_nxt_s = MSB_CODE;
               busy_nxt_s = 1'b1;
            end else begin
               busy_nxt_s = 1'b0;
            end
         end
         ST_SETTLE: begin
            if (cnt_r != CNT_ZERO) begin
               cnt_nxt_s = cnt_r - CNT_ONE;
            end else begin
               cnt_nxt_s = CNT_ZERO;
            end
         end
         ST_DECIDE: begin
            // Trial bit is already 1, so keeping it or clearing it equals comp_s
            code_nxt_s[idx_r] = comp_s;
            if (idx_r != IDX_ZERO) begin
               code_nxt_s[idx_r - IDX_ONE] = 1'b1;
               idx_nxt_s                   = idx_r - IDX_ONE;
               cnt_nxt_s                   = CNT_LOAD;
            end else begin
               result_nxt_s = code_nxt_s;
               valid_nxt_s  = 1'b1;
`ifdef R2R_SAR_CONTINUOUS_EN
               busy_nxt_s   = 1'b1;
`else
               busy_nxt_s   = 1'b0;
`endif
            end
         end
         ST_DONE: begin
`ifdef R2R_SAR_CONTINUOUS_EN
            idx_nxt_s  = IDX_MSB;
            cnt_nxt_s  = CNT_LOAD;
            code_nxt_s = MSB_CODE;
            busy_nxt_s = 1'b1;
`else
            busy_nxt_s = 1'b0;
`endif
         end
         default: begin
            busy_nxt_s = 1'b0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         idx_r    <= IDX_ZERO;
         cnt_r    <= CNT_ZERO;
         code_r   <= {WIDTH{1'b0}};
         result_r <= {WIDTH{1'b0}};
         valid_r  <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         idx_r    <= idx_nxt_s;
         cnt_r    <= cnt_nxt_s;
         code_r   <= code_nxt_s;
         result_r <= result_nxt_s;
         valid_r  <= valid_nxt_s;
         busy_r   <= busy_nxt_s;
      end
   end

   assign r2r_out = code_r;
   assign result  = result_r;
   assign valid   = valid_r;
   assign busy    = busy_r;

endmodule
